// File: rtl/hilo_divider_if.sv
// Request/result handshake between the ALU execute stage and the HI/LO divider.
// The ALU is the master; the divider is the slave.
interface hilo_divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               sign;
  logic               opn_valid;
  logic               res_ready;
  logic               res_valid;
  logic [2*WIDTH-1:0] result;

  modport master (
    output a,
    output b,
    output sign,
    output opn_valid,
    output res_ready,
    input  res_valid,
    input  result
  );

  modport slave (
    input  a,
    input  b,
    input  sign,
    input  opn_valid,
    input  res_ready,
    output res_valid,
    output result
  );
endinterface

// File: rtl/hilo_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, result held
// as {remainder, quotient} until the ALU takes it for HI/LO.
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  hilo_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rawA;
  logic [WIDTH:0]     r_rem;
  logic [CW-1:0]      r_count;
  logic               r_negQ;
  logic               r_negR;
  logic               r_divZero;
  logic [2*WIDTH-1:0] r_result;

  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [WIDTH:0]     w_nextRem;
  logic [WIDTH-1:0]   w_nextQuo;
  logic [WIDTH-1:0]   w_finalQ;
  logic [WIDTH-1:0]   w_finalR;
  logic               w_lastIter;

  // Operand magnitudes are only taken for signed requests.
  assign w_absA = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_absB = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // The dividend shifts out of r_quo into the remainder while quotient bits shift in.
  assign w_shifted  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_diff     = w_shifted - {1'b0, r_divisor};
  assign w_fits     = ~w_diff[WIDTH];
  assign w_nextRem  = w_fits ? w_diff : w_shifted;
  assign w_nextQuo  = {r_quo[WIDTH-2:0], w_fits};
  assign w_lastIter = (r_count == CW'(WIDTH - 1));

  assign w_finalQ = r_negQ ? -w_nextQuo : w_nextQuo;
  assign w_finalR = r_negR ? -w_nextRem[WIDTH-1:0] : w_nextRem[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A transfer wins over an abort when both could apply in DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.opn_valid) begin
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (!bus.opn_valid) begin
          w_nextState = IDLE;
        end else if (w_lastIter) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready || !bus.opn_valid) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divisor <= '0;
      r_quo     <= '0;
      r_rawA    <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.opn_valid) begin
            r_divisor <= w_absB;
            r_quo     <= w_absA;
            r_rawA    <= bus.a;
            r_rem     <= '0;
            r_count   <= '0;
            r_negQ    <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_negR    <= bus.sign & bus.a[WIDTH-1];
            r_divZero <= (bus.b == '0);
          end
        end
        BUSY: begin
          if (bus.opn_valid) begin
            r_rem   <= w_nextRem;
            r_quo   <= w_nextQuo;
            r_count <= r_count + CW'(1);
            // Divide by zero keeps the normal latency but reports {a, all ones}.
            if (w_lastIter) begin
              r_result <= r_divZero ? {r_rawA, {WIDTH{1'b1}}} : {w_finalR, w_finalQ};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.res_valid = (r_state == DONE);
  assign bus.result    = r_result;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed self-checking bench for hilo_divider: arithmetic cases, latency, hold,
// reset and opn_valid aborts, and back-to-back requests.
module tb_hilo_divider;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  int   edges;
  logic seenValid;
  logic [63:0] heldResult;

  hilo_divider_if #(.WIDTH(32)) bus ();

  hilo_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.a         = a;
    bus.b         = b;
    bus.sign      = s;
    bus.opn_valid = 1'b1;
  endtask

  task automatic waitResult(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.res_valid) break;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] expected);
    int n;
    applyStimulus(a, b, s);
    waitResult(n);
    checkOutput({tag, " latency"}, 64'(n), 64'd33);
    checkOutput({tag, " result"}, bus.result, expected);
    @(posedge clk);
    #1;
    bus.opn_valid = 1'b0;
    checkOutput({tag, " released"}, 64'(bus.res_valid), 64'd0);
  endtask

  initial begin
    bus.a         = '0;
    bus.b         = '0;
    bus.sign      = 1'b0;
    bus.opn_valid = 1'b0;
    bus.res_ready = 1'b1;
    rst           = 1'b1;
    #1;
    checkOutput("reset res_valid", 64'(bus.res_valid), 64'd0);
    checkOutput("reset result", bus.result, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] arithmetic cases");
    runOp("udiv 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    checkOutput("idle after transfer", 64'(bus.res_valid), 64'd0);
    runOp("sdiv -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    runOp("sdiv 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
    runOp("sdiv -100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    runOp("sdiv overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000});
    runOp("udiv big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0});
    runOp("udiv by zero", 32'h1234_5678, 32'h0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF});
    runOp("sdiv by zero", 32'h8000_0001, 32'h0, 1'b1, {32'h8000_0001, 32'hFFFF_FFFF});

    $display("[TB] hold with res_ready low");
    bus.res_ready = 1'b0;
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
    waitResult(edges);
    checkOutput("hold latency", 64'(edges), 64'd33);
    bus.a    = 32'd55;
    bus.b    = 32'd3;
    bus.sign = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold res_valid", 64'(bus.res_valid), 64'd1);
      checkOutput("hold result", bus.result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.opn_valid = 1'b0;
    checkOutput("hold transfer", 64'(bus.res_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("hold single transfer", 64'(bus.res_valid), 64'd0);

    $display("[TB] reset abort mid-operation");
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1);
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort res_valid", 64'(bus.res_valid), 64'd0);
    checkOutput("abort result", bus.result, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    waitResult(edges);
    checkOutput("reaccept latency", 64'(edges), 64'd33);
    checkOutput("reaccept result", bus.result, {32'h0000_0001, 32'hFFFF_FFFD});
    @(posedge clk);
    #1;
    bus.opn_valid = 1'b0;

    $display("[TB] opn_valid drop mid-operation");
    heldResult = bus.result;
    applyStimulus(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.opn_valid = 1'b0;
    seenValid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) seenValid = 1'b1;
    end
    checkOutput("drop no res_valid", 64'(seenValid), 64'd0);
    checkOutput("drop result kept", bus.result, {32'h0000_0001, 32'hFFFF_FFFD});

    $display("[TB] back-to-back requests");
    applyStimulus(32'd1000, 32'd10, 1'b0);
    waitResult(edges);
    checkOutput("b2b first latency", 64'(edges), 64'd33);
    checkOutput("b2b first result", bus.result, {32'd0, 32'd100});
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'h0001_0000;
    @(posedge clk);
    #1;
    checkOutput("b2b first transfer", 64'(bus.res_valid), 64'd0);
    waitResult(edges);
    checkOutput("b2b second latency", 64'(edges), 64'd33);
    checkOutput("b2b second result", bus.result, {32'h0000_FFFF, 32'h0000_FFFF});
    @(posedge clk);
    #1;
    bus.opn_valid = 1'b0;
    checkOutput("b2b second transfer", 64'(bus.res_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hilo_divider.md
# hilo_divider

Sequential radix-2 restoring divider that serves the ALU's DIV/DIVU requests over the opn_valid / res_ready / res_valid handshake. It sits in the execute stage beside the combinational multiplier. It latches the operands on request, iterates one quotient bit per cycle, and holds a 64-bit {remainder, quotient} result until the ALU accepts it. The result feeds HI/LO directly.

## Interface
- WIDTH, 32: operand width; the iteration count equals WIDTH.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high. The ALU drives it with reset OR execute-stage flush, so it also aborts an operation in flight.
- a  in  32  dividend; sampled only on the accept edge.
- b  in  32  divisor; sampled only on the accept edge.
- sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled on the accept edge.
- opn_valid  in  1  requester holds a valid operation; stays high until the result is taken.
- res_ready  in  1  requester can take the result this cycle.
- res_valid  out  1  result register holds a finished result.
- result  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}.

## Operation
- Three states:
  - IDLE → BUSY when opn_valid = 1.
  - BUSY → DONE after 32 iterations.
  - DONE → IDLE when res_valid & res_ready.
- Accept edge (IDLE with opn_valid = 1):
  - Latch |a| and |b| when sign = 1, raw a and b when sign = 0.
  - Latch neg_q = sign & (a[31] ^ b[31]) and neg_r = sign & a[31].
  - Clear the 33-bit partial remainder and the 5-bit iteration counter.
- Each BUSY edge:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from the 33-bit remainder.
  - If the difference is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - Counter increments; the edge with counter = 31 is the last iteration.
- Final iteration edge: load the result register in the same edge.
  - quotient = neg_q ? -q : q
  - remainder = neg_r ? -r : r
  - All arithmetic is mod 2^32.
- Divide by zero (b = 0, either sign): result = {a, 32'hFFFF_FFFF}, with the same latency; no exception is raised.
- Overflow case 0x8000_0000 / 0xFFFF_FFFF signed: quotient 0x8000_0000, remainder 0 (wrap, no trap).
- opn_valid falling in BUSY or DONE without a transfer: abort to IDLE on the next edge, res_valid = 0, result discarded.
- a, b and sign changing during BUSY or DONE: ignored.
- Back-to-back operations: on the transfer edge the state goes to IDLE. A new request still held on opn_valid is accepted on the following edge; there is no same-edge re-accept.

## Timing
- Reset values (asynchronous, effective immediately on rst = 1):
  - state = IDLE
  - res_valid = 0
  - result = 64'h0
  - counter, partial remainder and flags = 0
- rst asserted mid-BUSY or in DONE: the operation is dropped. The first edge after release starts from IDLE, and a request still held is re-accepted from scratch.
- Latency: with accept edge E0, iterations occur on E1..E32, and res_valid = 1 from just after E32. That is 33 cycles from the request cycle to result-visible.
- ALU stall: div_stallE = opn_valid & ~res_valid is high for exactly those 33 cycles when res_ready is waiting.
- res_valid and result stay stable while res_ready = 0 and opn_valid = 1.
- Transfer occurs on the edge where res_valid & res_ready; res_valid falls after that edge.
- res_valid is registered; it has no combinational path from any input.
- result changes only on the final-iteration edge or on reset.

## Test plan
- Unsigned: a = 100, b = 7, sign = 0, res_ready = 1 → res_valid exactly 33 cycles after the request, result = {32'd2, 32'd14}; then IDLE.
- Signed: a = -7 (0xFFFF_FFF9), b = 2, sign = 1 → result = {0xFFFF_FFFF, 0xFFFF_FFFD}. Also a = 7, b = -2 → {0x0000_0001, 0xFFFF_FFFD}.
- Edge values:
  - a = 0x8000_0000, b = 0xFFFF_FFFF, sign = 1 → {0, 0x8000_0000}.
  - Same operands with sign = 0 → {0x8000_0000, 0}.
  - b = 0, a = 0x1234_5678 → {0x1234_5678, 0xFFFF_FFFF}.
- Hold: res_ready = 0 for 10 cycles after res_valid → result is stable and res_valid stays 1. Raising res_ready gives one transfer, then res_valid = 0.
- Abort: pulse rst at iteration 15 → res_valid and result read 0 immediately. With opn_valid held, the new operation completes 33 cycles after rst release. Separately, dropping opn_valid mid-BUSY returns to IDLE with no res_valid.
- Back-to-back: two divisions with opn_valid held continuously → the second is accepted one edge after the first transfer, and both results are correct.
